msgpass_rqst_rd_sched: RTL

- Read scheduler for the message-pass buffer.
- Fetches a programmed run of request pages from the buffer's read port A. The registered read data feeds memShare_control_wrapper.rqst_addr_i.
- Holds the read address while the memShare controller flags a DRC (is_drc). Drives scu_memShare_busy for the whole run.
- Production replacement for the dummy address generator that sits upstream of the memShare control path.

---
 rtl/msgpass_rqst_rd_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/msgpass_rqst_rd_sched.sv
// -----------------------------------------------------------------------------
// msgpass_rqst_rd_sched
//
// Read scheduler for the message-pass buffer. A single-cycle rd_begin_i pulse
// starts a run: rqst_num_i request pages are read from buffer port A. The
// first page is at base_addr_i. The buffer's registered read data feeds the
// memShare controller's request address. While the controller flags a DRC,
// the read address is held so no page is skipped. busy_o covers the whole run.
//
// Ports
//   sys_clk        system clock, rising edge
//   rst            asynchronous active-high reset
//   rd_begin_i     start pulse; sampled only in IDLE
//   rd_abort_i     immediate return to IDLE; overrides everything else
//   base_addr_i    first buffer address of the run
//   rqst_num_i     number of pages; 0 gives an empty run, values above
//                  2^ADDR_WIDTH are clamped to 2^ADDR_WIDTH
//   is_drc_i       DRC flags from memShare control; any bit set = stall
//   raddr_o        buffer read address (port A)
//   ren_o          read address valid
//   rdata_valid_o  buffer rdata holds a valid request this cycle
//   last_o         raddr_o carries the final page of the run
//   busy_o         run in progress (READ or DRAIN)
//   done_o         one-cycle pulse when a run completes without abort
// -----------------------------------------------------------------------------
module msgpass_rqst_rd_sched #(
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 4,   // must be ADDR_WIDTH + 1
    parameter int DRC_NUM    = 1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  rd_begin_i,
    input  logic                  rd_abort_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  rqst_num_i,
    input  logic [DRC_NUM-1:0]    is_drc_i,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    output logic                  ren_o,
    output logic                  rdata_valid_o,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    // A run can cover every buffer address exactly once, never more.
    localparam logic [CNT_WIDTH-1:0] MAX_NUM = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  state;
    state_t                  stateNext;
    logic [ADDR_WIDTH-1:0]   raddrReg;
    logic                    renReg;
    logic                    rdataValidReg;
    logic [CNT_WIDTH-1:0]    issueCnt;      // pages issued so far, 1-based
    logic [CNT_WIDTH-1:0]    rqstNum;       // clamped page count of this run
    logic [CNT_WIDTH-1:0]    numClamped;
    logic                    stall;
    logic                    lastPage;

    assign stall      = |is_drc_i;
    assign lastPage   = (issueCnt == rqstNum);
    assign numClamped = (rqst_num_i > MAX_NUM) ? MAX_NUM : rqst_num_i;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking assignments here would create order-dependent
    // simulation and mismatch synthesis.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: stateNext gets a default before the case so every path assigns
    // it; a missing assignment on any branch would infer a latch.
    always_comb begin
        stateNext = state;
        if (rd_abort_i) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (rd_begin_i) stateNext = (rqst_num_i == '0) ? FIN : READ;
                READ:    if (!stall && lastPage) stateNext = DRAIN;
                DRAIN:   if (!stall) stateNext = FIN;
                FIN:     stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------- datapath
    // NOTE: every register here, including the latched page count, is reset;
    // this is a handful of flops rather than a memory array, so resetting
    // them costs nothing and keeps last_o well defined out of reset.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            raddrReg      <= '0;
            renReg        <= 1'b0;
            rdataValidReg <= 1'b0;
            issueCnt      <= '0;
            rqstNum       <= '0;
        end else if (rd_abort_i) begin
            // raddrReg is left as-is; ren_o low makes its value irrelevant.
            renReg        <= 1'b0;
            rdataValidReg <= 1'b0;
            issueCnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rdataValidReg <= 1'b0;
                    if (rd_begin_i) begin
                        rqstNum <= numClamped;
                        if (rqst_num_i != '0) begin
                            raddrReg <= base_addr_i;
                            renReg   <= 1'b1;
                            issueCnt <= CNT_WIDTH'(1);
                        end
                    end
                end
                READ: begin
                    // rdata lags the address by one cycle. During a stall
                    // both the address and ren are held, so the held rdata
                    // stays valid.
                    rdataValidReg <= renReg;
                    if (!stall) begin
                        if (lastPage) begin
                            renReg <= 1'b0;
                        end else begin
                            raddrReg <= raddrReg + ADDR_WIDTH'(1);  // wraps modulo 2^ADDR_WIDTH
                            issueCnt <= issueCnt + CNT_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Hold the final rdata valid until the controller accepts it.
                    if (!stall) rdataValidReg <= 1'b0;
                end
                default: begin
                    rdataValidReg <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------ outputs
    assign raddr_o       = raddrReg;
    assign ren_o         = renReg;
    assign rdata_valid_o = rdataValidReg;
    assign last_o        = (state == READ) && lastPage;
    assign busy_o        = (state == READ) || (state == DRAIN);
    assign done_o        = (state == FIN);

endmodule
